em_pipe_reg: RTL

- Parametrised EX→MEM pipeline boundary register for the MIPS datapath.
- Carries the ALU result, store data, destination register and control bits from Execute to Memory.
- Adds valid/ready flow control with an optional one-entry skid buffer, so a slow data memory can stall the pipe without a combinational ready path back into Execute.
- Adds a synchronous flush that kills in-flight instructions, and a memory-access-size field.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 41 ++++
 rtl/em_pipe_reg.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, memory access size codes
// and the EX->MEM payload layout.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_SIZE_W     = 2;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]     alu_out;
    logic [DEF_DATA_W-1:0]     write_data;
    logic [DEF_REG_ADDR_W-1:0] write_reg;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      mem_write;
    logic [DEF_SIZE_W-1:0]     mem_size;
  } em_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a payload register with load enable plus a
// valid bit that is rewritten every cycle.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         valid_d_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/em_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, optional one-entry
// skid buffer (registered ReadyE), synchronous flush and access-size field.
module em_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int SIZE_W     = DEF_SIZE_W,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FlushM,
  input  logic                  ValidE,
  output logic                  ReadyE,
  input  logic [DATA_W-1:0]     ALUOutE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  MemWriteE,
  input  logic [SIZE_W-1:0]     MemSizeE,
  output logic                  ValidM,
  input  logic                  ReadyM,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  MemWriteM,
  output logic [SIZE_W-1:0]     MemSizeM,
  output logic [1:0]            Occupancy
);

  localparam int PW = 2 * DATA_W + REG_ADDR_W + 3 + SIZE_W;

  logic [PW-1:0] pay_e, main_in, main_data, skid_data;
  logic [1:0]    occ_q, occ_d;
  logic          main_v, skid_v;
  logic          main_load, skid_load, main_from_skid;
  logic          in_fire, out_fire;
  logic          rw_raw, mw_raw;

  assign pay_e    = {ALUOutE, WriteDataE, WriteRegE, RegWriteE, MemtoRegE, MemWriteE, MemSizeE};
  assign in_fire  = ValidE & ReadyE;
  assign out_fire = main_v & ReadyM;

  always_comb begin
    occ_d          = occ_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (FlushM) begin
      occ_d = OCC_EMPTY;
    end else if (SKID != 0) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            occ_d     = OCC_ONE;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            occ_d     = OCC_TWO;
          end else if (out_fire) begin
            occ_d = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // The skid entry is always younger, so it refills main on drain.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            occ_d          = OCC_ONE;
          end else begin
            occ_d = OCC_TWO;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end else begin
      if (in_fire) begin
        main_load = 1'b1;
        occ_d     = OCC_ONE;
      end else if (out_fire) begin
        occ_d = OCC_EMPTY;
      end else begin
        occ_d = occ_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign main_in = main_from_skid ? skid_data : pay_e;

  pipe_slot #(.W(PW)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load_i    (main_load),
    .valid_d_i (occ_d != OCC_EMPTY),
    .data_i    (main_in),
    .valid_o   (main_v),
    .data_o    (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.W(PW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load_i    (skid_load),
      .valid_d_i (occ_d == OCC_TWO),
      .data_i    (pay_e),
      .valid_o   (skid_v),
      .data_o    (skid_data)
    );
    assign ReadyE = ~reset & ~skid_v;
  end else begin : g_noskid
    assign skid_v    = 1'b0;
    assign skid_data = '0;
    assign ReadyE    = ~reset & (~main_v | ReadyM);
  end

  assign {ALUOutM, WriteDataM, WriteRegM, rw_raw, MemtoRegM, mw_raw, MemSizeM} = main_data;
  assign ValidM    = main_v;
  assign RegWriteM = rw_raw & main_v;
  assign MemWriteM = mw_raw & main_v;
  assign Occupancy = skid_v ? OCC_TWO : (main_v ? OCC_ONE : OCC_EMPTY);

endmodule
